beamform_seq_ctrl: RTL and testbench

Sequencer and weight-bank controller for the 4-element complex linear combiner. It accepts antenna snapshots through a valid/ready handshake and drives them into the combiner together with a frozen "active" weight set. Weight updates from the adaptation engine are written into a shadow bank and swapped into the active bank only at a frame boundary, after the combiner pipeline has drained. It also emits the combined output with valid and frame markers.

---
 rtl/beamform_seq_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_beamform_seq_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beamform_seq_ctrl.sv
// beamform_seq_ctrl: snapshot sequencer and double-buffered weight bank for a
// 4-element complex linear combiner. Snapshots stream through a valid/ready
// handshake; shadow weights become active only at a drained frame boundary.
module beamform_seq_ctrl #(
  parameter int W         = 18,
  parameter int CMB_LAT   = 3,
  parameter int FRAME_LEN = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [8*W-1:0] s_u,
  input  logic           wr_en,
  output logic           wr_ready,
  input  logic [1:0]     wr_idx,
  input  logic [W-1:0]   wr_wI,
  input  logic [W-1:0]   wr_wQ,
  input  logic           commit,
  output logic           commit_pending,
  output logic           commit_done,
  output logic [8*W-1:0] c_u,
  output logic [8*W-1:0] c_w,
  input  logic [W-1:0]   c_yI,
  input  logic [W-1:0]   c_yQ,
  output logic           m_valid,
  output logic [W-1:0]   m_yI,
  output logic [W-1:0]   m_yQ,
  output logic           m_first,
  output logic           m_last,
  output logic           busy
);

  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int DW = $clog2(CMB_LAT + 2);
  localparam logic [FW-1:0] FCNT_LAST = FW'(FRAME_LEN - 1);
  // DRAIN lasts CMB_LAT+2 cycles: counter runs 0 .. CMB_LAT+1.
  localparam logic [DW-1:0] DCNT_LAST = DW'(CMB_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_SWAP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            pend_q, pend_d;
  logic [8*W-1:0]  shadow_q;
  logic [8*W-1:0]  active_q;
  logic [8*W-1:0]  c_u_q;
  // Tag = {valid, first, last}; tag_u_q is aligned with c_u, the shift
  // register then tracks the combiner so its tail lines up with c_y.
  logic [2:0]              tag_u_q;
  logic [CMB_LAT:0][2:0]   tag_pipe_q;
  logic            m_valid_q, m_first_q, m_last_q;
  logic [W-1:0]    m_yI_q, m_yQ_q;

  logic accept_s;
  logic req_s;
  logic wr_fire_s;

  assign accept_s  = (state_q == ST_RUN) && s_valid;
  // A commit arriving in the same cycle as the decision counts immediately.
  assign req_s     = pend_q || commit;
  assign wr_fire_s = wr_en && (state_q != ST_SWAP);

  // Next-state logic for the sequencer FSM plus frame and drain counters.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RUN;
        else    state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (accept_s) begin
          if (fcnt_q == FCNT_LAST) begin
            fcnt_d = '0;
            if (req_s || !en) begin
              state_d = ST_DRAIN;
              dcnt_d  = '0;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            fcnt_d = fcnt_q + FW'(1);
          end
        end else begin
          fcnt_d = fcnt_q;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DCNT_LAST) begin
          if (req_s)   state_d = ST_SWAP;
          else if (en) state_d = ST_RUN;
          else         state_d = ST_IDLE;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      ST_SWAP: begin
        if (en) state_d = ST_RUN;
        else    state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Commit request flag: set by commit, cleared by the swap, deaf during SWAP.
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_SWAP) pend_d = 1'b0;
    else if (commit)        pend_d = 1'b1;
    else                    pend_d = pend_q;
  end

  // FSM state, counters and commit flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      fcnt_q  <= '0;
      dcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      dcnt_q  <= dcnt_d;
      pend_q  <= pend_d;
    end
  end

  // Shadow bank writes and atomic shadow-to-active copy in SWAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_fire_s && (wr_idx == 2'(i))) begin
          shadow_q[i*2*W +: 2*W] <= {wr_wQ, wr_wI};
        end
      end
      if (state_q == ST_SWAP) begin
        active_q <= shadow_q;
      end
    end
  end

  // Snapshot register toward the combiner and the tag shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_u_q      <= '0;
      tag_u_q    <= 3'b000;
      tag_pipe_q <= '0;
    end else begin
      if (accept_s) begin
        c_u_q   <= s_u;
        tag_u_q <= {1'b1, (fcnt_q == '0), (fcnt_q == FCNT_LAST)};
      end else begin
        tag_u_q <= 3'b000;
      end
      tag_pipe_q[0] <= tag_u_q;
      for (int i = 1; i <= CMB_LAT; i++) begin
        tag_pipe_q[i] <= tag_pipe_q[i-1];
      end
    end
  end

  // Output register: combiner result plus markers from the tag tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_first_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_yI_q    <= '0;
      m_yQ_q    <= '0;
    end else begin
      m_valid_q <= tag_pipe_q[CMB_LAT][2];
      m_first_q <= tag_pipe_q[CMB_LAT][1];
      m_last_q  <= tag_pipe_q[CMB_LAT][0];
      m_yI_q    <= c_yI;
      m_yQ_q    <= c_yQ;
    end
  end

  assign s_ready        = (state_q == ST_RUN);
  assign wr_ready       = (state_q != ST_SWAP);
  assign commit_done    = (state_q == ST_SWAP);
  assign busy           = (state_q != ST_IDLE);
  assign commit_pending = pend_q;
  assign c_u            = c_u_q;
  assign c_w            = active_q;
  assign m_valid        = m_valid_q;
  assign m_first        = m_first_q;
  assign m_last         = m_last_q;
  assign m_yI           = m_yI_q;
  assign m_yQ           = m_yQ_q;

endmodule

// File: tb/tb_beamform_seq_ctrl.sv
// Testbench for beamform_seq_ctrl: directed vector table, corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_beamform_seq_ctrl;

  localparam int W  = 18;
  localparam int CL = 3;
  localparam int FL = 4;
  localparam logic [W-1:0] ZW  = 18'h00000;
  localparam logic [W-1:0] ONE = 18'h01000;

  logic           clk;
  logic           rst, en, s_valid, wr_en, commit;
  logic [8*W-1:0] s_u;
  logic [1:0]     wr_idx;
  logic [W-1:0]   wr_wI, wr_wQ;
  logic           s_ready, wr_ready, commit_pending, commit_done, busy;
  logic [8*W-1:0] c_u, c_w;
  logic [W-1:0]   c_yI, c_yQ;
  logic           m_valid, m_first, m_last;
  logic [W-1:0]   m_yI, m_yQ;

  beamform_seq_ctrl #(.W(W), .CMB_LAT(CL), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .en(en), .s_valid(s_valid), .s_ready(s_ready),
    .s_u(s_u), .wr_en(wr_en), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_wI(wr_wI), .wr_wQ(wr_wQ), .commit(commit),
    .commit_pending(commit_pending), .commit_done(commit_done),
    .c_u(c_u), .c_w(c_w), .c_yI(c_yI), .c_yQ(c_yQ),
    .m_valid(m_valid), .m_yI(m_yI), .m_yQ(m_yQ),
    .m_first(m_first), .m_last(m_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Complex dot product in Q12 weights, truncated to W bits per component.
  function automatic logic [2*W-1:0] cmb_f(input logic [8*W-1:0] u, input logic [8*W-1:0] w);
    longint si, sq, ui, uq, wi, wq;
    si = 0; sq = 0;
    for (int k = 0; k < 4; k++) begin
      ui = longint'($signed(u[(2*k)*W +: W]));
      uq = longint'($signed(u[(2*k+1)*W +: W]));
      wi = longint'($signed(w[(2*k)*W +: W]));
      wq = longint'($signed(w[(2*k+1)*W +: W]));
      si = si + ui*wi - uq*wq;
      sq = sq + ui*wq + uq*wi;
    end
    si = si >>> 12;
    sq = sq >>> 12;
    return {sq[W-1:0], si[W-1:0]};
  endfunction

  // Combiner stand-in: registers c_u/c_w, then CL more stages.
  logic [2*W-1:0] cmb_pipe [CL+1];
  initial for (int i = 0; i <= CL; i++) cmb_pipe[i] = '0;
  always @(posedge clk) begin
    cmb_pipe[0] <= cmb_f(c_u, c_w);
    for (int i = 1; i <= CL; i++) cmb_pipe[i] <= cmb_pipe[i-1];
  end
  assign c_yI = cmb_pipe[CL][W-1:0];
  assign c_yQ = cmb_pipe[CL][2*W-1:W];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit mdl_en  = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int           due;
    logic [W-1:0] yi, yq;
    bit           f, l;
  } exp_t;
  exp_t sbq[$];

  bit             mo_on, mo_swap, mo_pend;
  int             mo_gap, mo_cnt;
  logic [8*W-1:0] mo_u;
  logic [W-1:0]   sh_i [4], sh_q [4], ac_i [4], ac_q [4];

  function automatic logic [8*W-1:0] pack_w();
    logic [8*W-1:0] v;
    for (int k = 0; k < 4; k++) begin
      v[(2*k)*W +: W]   = ac_i[k];
      v[(2*k+1)*W +: W] = ac_q[k];
    end
    return v;
  endfunction

  task automatic model_reset();
    mo_on = 1'b0; mo_swap = 1'b0; mo_pend = 1'b0;
    mo_gap = 0; mo_cnt = 0; mo_u = '0;
    for (int k = 0; k < 4; k++) begin
      sh_i[k] = '0; sh_q[k] = '0; ac_i[k] = '0; ac_q[k] = '0;
    end
    sbq.delete();
  endtask

  task automatic model_step();
    bit   e_swap, e_srdy, req;
    exp_t e;
    e_swap = mo_on && mo_swap;
    e_srdy = mo_on && (mo_gap == 0) && !mo_swap;
    if (mdl_en) begin
      chk("ctrl", {s_ready, busy, commit_done, wr_ready, commit_pending},
                  {e_srdy, mo_on, e_swap, !e_swap, mo_pend});
      chk("c_w", c_w, pack_w());
      chk("c_u", c_u, mo_u);
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        chk("m_out", {m_valid, m_first, m_last, m_yQ, m_yI},
                     {1'b1, sbq[0].f, sbq[0].l, sbq[0].yq, sbq[0].yi});
        void'(sbq.pop_front());
      end else begin
        chk("m_valid_idle", m_valid, 1'b0);
      end
    end
    if (rst) begin
      model_reset();
    end else begin
      req = mo_pend || commit;
      if (wr_en && !e_swap) begin
        sh_i[wr_idx] = wr_wI;
        sh_q[wr_idx] = wr_wQ;
      end
      if (e_swap) begin
        for (int k = 0; k < 4; k++) begin
          ac_i[k] = sh_i[k]; ac_q[k] = sh_q[k];
        end
        mo_pend = 1'b0; mo_swap = 1'b0; mo_on = en;
      end else begin
        if (commit) mo_pend = 1'b1;
        if (!mo_on) begin
          mo_on = en;
        end else if (mo_gap > 0) begin
          mo_gap--;
          if (mo_gap == 0) begin
            if (req)      mo_swap = 1'b1;
            else if (!en) mo_on = 1'b0;
          end
        end else if (s_valid) begin
          e.due = cyc + CL + 3;
          {e.yq, e.yi} = cmb_f(s_u, pack_w());
          e.f = (mo_cnt == 0);
          e.l = (mo_cnt == FL - 1);
          sbq.push_back(e);
          mo_u = s_u;
          mo_cnt++;
          if (mo_cnt == FL) begin
            mo_cnt = 0;
            if (req || !en) mo_gap = CL + 2;
          end
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  logic [6:0]   ob7;   // {s_ready,busy,commit_pending,commit_done,m_valid,m_first,m_last}
  logic [W-1:0] ob_w1;

  function automatic logic [8*W-1:0] rand_u();
    logic [8*W-1:0] v;
    for (int k = 0; k < 8; k++) v[k*W +: W] = W'($urandom);
    return v;
  endfunction

  task automatic step(input bit r_v, input bit en_v, input bit sv_v, input logic [8*W-1:0] u_v,
                      input bit wr_v, input logic [1:0] idx_v, input logic [W-1:0] wi_v,
                      input logic [W-1:0] wq_v, input bit cm_v);
    @(negedge clk);
    rst = r_v; en = en_v; s_valid = sv_v; s_u = u_v;
    wr_en = wr_v; wr_idx = idx_v; wr_wI = wi_v; wr_wQ = wq_v; commit = cm_v;
    #1;
    ob7   = {s_ready, busy, commit_pending, commit_done, m_valid, m_first, m_last};
    ob_w1 = c_w[W-1:0];
    model_step();
    cyc++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctl"}, {s_ready, wr_ready, commit_done, busy, commit_pending}, 5'b01000);
    chk({tag, "_cu"}, c_u, '0);
    chk({tag, "_cw"}, c_w, '0);
    chk({tag, "_m"}, {m_valid, m_first, m_last, m_yI, m_yQ}, '0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit           en, sv, wr, cm;
    logic [W-1:0] wi;
    logic [6:0]   ex;   // {srdy,busy,pend,done,mv,mf,ml}
    logic [W-1:0] w1i;
  } vec_t;
  vec_t tbl [22];

  function automatic vec_t mk(input bit en_v, input bit sv_v, input bit wr_v, input bit cm_v,
                              input logic [W-1:0] wi_v, input logic [6:0] ex_v,
                              input logic [W-1:0] w1_v);
    vec_t v;
    v.en = en_v; v.sv = sv_v; v.wr = wr_v; v.cm = cm_v;
    v.wi = wi_v; v.ex = ex_v; v.w1i = w1_v;
    return v;
  endfunction

  bit             seen_done, reached;
  logic [8*W-1:0] cw_expect;

  initial begin
    // FL=4, CL=3: accept in cycle k -> output in cycle k+6; drain 5 + swap 1.
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, ZW,  7'b0000000, ZW);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, ZW,  7'b1100000, ZW);
    tbl[2]  = mk(1'b1, 1'b1, 1'b1, 1'b1, ONE, 7'b1100000, ZW);
    tbl[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, ZW,  7'b1110000, ZW);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 1'b0, ZW,  7'b1110000, ZW);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, ZW,  7'b0110000, ZW);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, ZW,  7'b0110000, ZW);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, ZW,  7'b0110110, ZW);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, ZW,  7'b0110100, ZW);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, ZW,  7'b0110100, ZW);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 1'b1, ZW,  7'b0111101, ZW);
    tbl[11] = mk(1'b1, 1'b1, 1'b0, 1'b0, ZW,  7'b1100000, ONE);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 1'b0, ZW,  7'b1100000, ONE);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b0, ZW,  7'b1100000, ONE);
    tbl[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, ZW,  7'b1100000, ONE);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, ZW,  7'b0100000, ONE);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, ZW,  7'b0100000, ONE);
    tbl[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, ZW,  7'b0100110, ONE);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, ZW,  7'b0100100, ONE);
    tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, ZW,  7'b0100100, ONE);
    tbl[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, ZW,  7'b0000101, ONE);
    tbl[21] = mk(1'b0, 1'b0, 1'b0, 1'b0, ZW,  7'b0000000, ONE);

    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_u = '0; wr_en = 1'b0;
    wr_idx = 2'd0; wr_wI = '0; wr_wQ = '0; commit = 1'b0;
    model_reset();

    // Reset, then check every output against its reset value.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0, 2'd0, ZW, ZW, 1'b0);
    @(posedge clk); #1;
    chk_reset_vals("reset");
    mdl_en = 1'b1;

    // Directed table: basic stream, commit mid-frame, swap, en drop.
    for (int i = 0; i < 22; i++) begin
      step(1'b0, tbl[i].en, tbl[i].sv, rand_u(), tbl[i].wr, 2'd0, tbl[i].wi, ZW, tbl[i].cm);
      chk($sformatf("row%0d_flags", i), ob7, tbl[i].ex);
      chk($sformatf("row%0d_w1I", i), ob_w1, tbl[i].w1i);
    end

    // Write and commit on the last sample of a frame; commit again in SWAP.
    seen_done = 1'b0;
    step(1'b0, 1'b1, 1'b0, '0, 1'b0, 2'd0, ZW, ZW, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, rand_u(), (i == 3), 2'd2, 18'h02abc, 18'h3ff00,
           (i == 3) || (i == 9));
      if (i == 9) seen_done = ob7[3];
    end
    chk("swap_pulse", seen_done, 1'b1);
    step(1'b0, 1'b1, 1'b1, rand_u(), 1'b0, 2'd0, ZW, ZW, 1'b0);
    chk("no_rearm", ob7[4], 1'b0);
    cw_expect = '0;
    cw_expect[W-1:0] = ONE;
    cw_expect[4*W +: 2*W] = {18'h3ff00, 18'h02abc};
    chk("swap_incl_write", c_w, cw_expect);

    // Gapped input, one valid cycle in three.
    for (int i = 0; i < 36; i++)
      step(1'b0, 1'b1, (i % 3 == 0), rand_u(), 1'b0, 2'd0, ZW, ZW, 1'b0);

    // Commit, run into DRAIN, then reset in the middle of it.
    step(1'b0, 1'b1, 1'b1, rand_u(), 1'b1, 2'd1, 18'h00123, 18'h00456, 1'b1);
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b1, rand_u(), 1'b0, 2'd0, ZW, ZW, 1'b0);
      if (ob7[6] == 1'b0 && ob7[5] == 1'b1) begin
        reached = 1'b1;
        break;
      end
    end
    chk("reach_drain", reached, 1'b1);
    step(1'b0, 1'b1, 1'b1, rand_u(), 1'b0, 2'd0, ZW, ZW, 1'b0);
    step(1'b1, 1'b1, 1'b1, rand_u(), 1'b0, 2'd0, ZW, ZW, 1'b0);
    @(posedge clk); #1;
    chk_reset_vals("rst_drain");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, rand_u(), 1'b0, 2'd0, ZW, ZW, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) != 0), rand_u(),
           ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           W'($urandom), W'($urandom), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
